// File: rtl/cu_pkg.sv
// Shared definitions for the UAZ control unit: opcodes, register-file write
// codes, sequencer states and next-PC select codes.
package cu_pkg;

   // Opcode field values (IR[15:12]); 4'h2..4'h7 are ALU operations
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LDI   = 4'h1;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JZ    = 4'h9;
   localparam logic [3:0] OP_JNZ   = 4'hA;
   localparam logic [3:0] OP_CALL  = 4'hB;
   localparam logic [3:0] OP_RET   = 4'hC;
   localparam logic [3:0] OP_RSV_D = 4'hD;
   localparam logic [3:0] OP_RSV_E = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Register-file write select codes
   localparam logic [2:0] HAB_NONE = 3'b000;
   localparam logic [2:0] HAB_R0   = 3'b001;
   localparam logic [2:0] HAB_R7   = 3'b011;
   localparam logic [2:0] HAB_RX   = 3'b100;

   // Next-PC source chosen by the decoder during EXEC
   localparam logic [1:0] PCSEL_INC  = 2'd0;
   localparam logic [1:0] PCSEL_IMM  = 2'd1;
   localparam logic [1:0] PCSEL_RET  = 2'd2;
   localparam logic [1:0] PCSEL_HOLD = 2'd3;

   // Sequencer states; S_STEP is only reachable in single-step builds
   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT,
      S_STEP
   } state_t;

   // ALU operations occupy opcodes 2..7; alu_op is the low three bits
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= 4'h2) && (op <= 4'h7);
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: turns IR, the Z flag and PC into
// register-file write controls, ALU opcode and next-PC source. Every
// write-type output stays inactive unless exec_en is high.
module cu_decoder
   import cu_pkg::*;
(
   input  logic        exec_en,
   input  logic [15:0] ir,
   input  logic        z,
   input  logic [7:0]  pc,
   output logic [2:0]  hab,
   output logic [2:0]  rx,
   output logic [2:0]  ry,
   output logic [7:0]  dato,
   output logic [7:0]  pc_val,
   output logic [2:0]  alu_op,
   output logic [1:0]  pc_sel,
   output logic        z_we,
   output logic        halt
);

   logic [3:0] op;
   logic [7:0] imm;

   assign op  = ir[15:12];
   assign imm = ir[7:0];

   // Decode IR into control outputs; only EXEC produces non-idle values
   always_comb begin
      // NOTE: every output gets a default before any branch so no path can
      // leave one unassigned and infer a latch.
      hab    = HAB_NONE;
      rx     = ir[11:9];
      ry     = ir[8:6];
      dato   = 8'h00;
      pc_val = 8'h00;
      alu_op = 3'd0;
      pc_sel = PCSEL_INC;
      z_we   = 1'b0;
      halt   = 1'b0;

      if (exec_en) begin
         case (op)
            OP_LDI: begin
               hab  = HAB_RX;
               dato = imm;
            end
            OP_JMP:  pc_sel = PCSEL_IMM;
            OP_JZ:   pc_sel = z ? PCSEL_IMM : PCSEL_INC;
            OP_JNZ:  pc_sel = z ? PCSEL_INC : PCSEL_IMM;
            OP_CALL: begin
               hab    = HAB_R7;
               pc_val = pc + 8'd1;
               pc_sel = PCSEL_IMM;
            end
            OP_RET: begin
               // Return address lives in R7; point read port X at it
               rx     = 3'd7;
               pc_sel = PCSEL_RET;
            end
            OP_HALT: begin
               pc_sel = PCSEL_HOLD;
               halt   = 1'b1;
            end
            OP_NOP, OP_RSV_D, OP_RSV_E: pc_sel = PCSEL_INC;
            default: begin
               if (is_alu_op(op)) begin
                  hab    = HAB_R0;
                  alu_op = op[2:0];
                  z_we   = 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit UAZ core. Owns PC, IR and
// the Z flag, reads a synchronous instruction ROM and drives the register
// file write controls and ALU opcode. Three cycles per instruction.
// Optional feature: define CU_SINGLE_STEP_EN to add the `step` input and a
// S_STEP wait state after every EXEC.
module control_unit
   import cu_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         IW       = 16
)(
   input  logic          clk,
   input  logic          reset,
`ifdef CU_SINGLE_STEP_EN
   input  logic          step,
`endif
   output logic [7:0]    imem_addr,
   input  logic [IW-1:0] imem_data,
   input  logic          alu_zero,
   input  logic [7:0]    RX_DATO,
   output logic [2:0]    alu_op,
   output logic [2:0]    HAB,
   output logic [2:0]    RX,
   output logic [2:0]    RY,
   output logic [7:0]    DATO,
   output logic [7:0]    PC_VAL,
   output logic          halted
);

   state_t        state_q, state_d;
   logic [7:0]    pc_q, pc_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          z_q, z_d;

   logic          exec_en;
   logic [1:0]    pc_sel;
   logic          z_we;
   logic          halt;

   // Reset overrides EXEC combinationally so no write strobe escapes in the
   // cycle reset is asserted.
   assign exec_en   = (state_q == S_EXEC) && !reset;
   assign imem_addr = pc_q;
   assign halted    = (state_q == S_HALT);

   cu_decoder u_decoder (
      .exec_en (exec_en),
      .ir      (ir_q),
      .z       (z_q),
      .pc      (pc_q),
      .hab     (HAB),
      .rx      (RX),
      .ry      (RY),
      .dato    (DATO),
      .pc_val  (PC_VAL),
      .alu_op  (alu_op),
      .pc_sel  (pc_sel),
      .z_we    (z_we),
      .halt    (halt)
   );

   // Next-state, PC, IR and Z computation
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      z_d     = z_q;

      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            // ROM data for the address presented in FETCH is valid now
            ir_d    = imem_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (pc_sel)
               PCSEL_INC: pc_d = pc_q + 8'd1;
               PCSEL_IMM: pc_d = ir_q[7:0];
               PCSEL_RET: pc_d = RX_DATO;
               default:   pc_d = pc_q;
            endcase
            if (z_we) begin
               z_d = alu_zero;
            end
            if (halt) begin
               state_d = S_HALT;
            end else begin
`ifdef CU_SINGLE_STEP_EN
               state_d = S_STEP;
`else
               state_d = S_FETCH;
`endif
            end
         end
         S_HALT:   state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
         S_STEP:   state_d = step ? S_FETCH : S_STEP;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
      end
   end

endmodule
